// File: rtl/dr_flag_capture_pkg.sv
// Shared definitions for the dual-rail flag capture stage.
// Contents:
//   DR_* rail-code constants for one dual-rail pair {true, false}.
//   state_t, the two capture FSM states.
//   Pair helper functions used by the synchronizer's completion detector.
package dr_flag_capture_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_ONE  = 2'b10;
  localparam logic [1:0] DR_ZERO = 2'b01;
  localparam logic [1:0] DR_ILL  = 2'b11;

  typedef enum logic {
    WAIT_DATA = 1'b0,
    WAIT_NULL = 1'b1
  } state_t;

  // A pair carries DATA (legal or not) as soon as either rail is high.
  function automatic logic dr_pair_present(input logic [1:0] pair);
    return pair != DR_NULL;
  endfunction

  function automatic logic dr_pair_illegal(input logic [1:0] pair);
    return (pair != DR_ONE) && (pair != DR_ZERO) && (pair != DR_NULL);
  endfunction

endpackage

// File: rtl/dr_flag_capture_if.sv
// Single-rail valid/ready output bus of the capture stage.
// Handshake: a word transfers on every rising edge where o_valid && o_ready.
// While o_valid is high and o_ready is low, o_result/o_flag hold steady.
// Signals:
//   o_valid  - word available (master drives)
//   o_ready  - consumer accepts (slave drives)
//   o_result - single-rail result, WIDTH bits
//   o_flag   - single-rail flag
interface dr_flag_capture_if #(
  parameter int WIDTH = 2
) ();
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_flag;

  modport master (output o_valid, output o_result, output o_flag, input o_ready);
  modport slave  (input o_valid, input o_result, input o_flag, output o_ready);
endinterface

// File: rtl/dr_flag_capture_sync_stable.sv
// Two-flop synchronizer for a bundle of dual-rail pairs plus a third
// history stage used to detect that the synchronized code has settled.
// Ports:
//   clk, rst_n  - clock, async active-low reset (all stages reset to NULL)
//   rails_i     - raw asynchronous rails, PAIRS pairs of {true, false}
//   rails_o     - synchronized rails (s2)
//   stable_o    - s2 equal to previous s2 (s3)
//   complete_o  - stable and no pair is NULL
//   null_o      - stable and every pair is NULL
//   bad_o       - complete and at least one pair is 11
module dr_sync_stable
  import dr_flag_capture_pkg::*;
#(
  parameter int PAIRS = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*PAIRS-1:0] rails_i,
  output logic [2*PAIRS-1:0] rails_o,
  output logic               stable_o,
  output logic               complete_o,
  output logic               null_o,
  output logic               bad_o
);

  logic [2*PAIRS-1:0] s1_q, s2_q, s3_q;
  logic               all_present, all_null, any_ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= rails_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    all_present = 1'b1;
    all_null    = 1'b1;
    any_ill     = 1'b0;
    for (int i = 0; i < PAIRS; i++) begin
      if (dr_pair_present(s2_q[2*i +: 2])) all_null    = 1'b0;
      else                                 all_present = 1'b0;
      if (dr_pair_illegal(s2_q[2*i +: 2])) any_ill     = 1'b1;
    end
  end

  // Requiring two equal consecutive samples filters single-cycle glitches
  // and partially arrived waves caught mid-transition.
  assign rails_o    = s2_q;
  assign stable_o   = (s2_q == s3_q);
  assign complete_o = stable_o && all_present;
  assign null_o     = stable_o && all_null;
  assign bad_o      = complete_o && any_ill;

endmodule

// File: rtl/dr_flag_capture.sv
// Clocked consumer of the dual-rail ALU flag detector. Captures a complete
// dual-rail {flag, result} wave, converts it to single rail, offers it on a
// valid/ready bus, and returns a four-phase ack to the dual-rail pipeline.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   in_result_dr  - dual-rail result, pair i = {[2i+1] true, [2i] false}
//   in_flag_dr    - dual-rail flag, {[1] true, [0] false}
//   ack_o         - four-phase acknowledge upstream
//   out_bus       - valid/ready single-rail output (o_valid/o_ready/o_result/o_flag)
//   err_illegal   - sticky: an 11 rail code was seen in a complete wave
//   word_cnt      - words delivered to o_valid, wraps
//   dbg_state_o   - current FSM state
module dr_flag_capture
  import dr_flag_capture_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*WIDTH-1:0]    in_result_dr,
  input  logic [1:0]            in_flag_dr,
  output logic                  ack_o,
  dr_flag_capture_if.master     out_bus,
  output logic                  err_illegal,
  output logic [CNT_W-1:0]      word_cnt,
  output state_t                dbg_state_o
);

  localparam int PAIRS = WIDTH + 1;

  logic [2*PAIRS-1:0] rails_s;
  logic               stable_s, complete_s, null_s, bad_s;

  // Flag occupies the top pair of the synchronized bundle.
  dr_sync_stable #(.PAIRS(PAIRS)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rails_i    ({in_flag_dr, in_result_dr}),
    .rails_o    (rails_s),
    .stable_o   (stable_s),
    .complete_o (complete_s),
    .null_o     (null_s),
    .bad_o      (bad_s)
  );

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_q, flag_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_true;
  logic               slot_free;

  always_comb begin
    result_true = '0;
    for (int i = 0; i < WIDTH; i++) result_true[i] = rails_s[2*i+1];
  end

  assign slot_free = !valid_q || out_bus.o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_DATA;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    valid_d  = valid_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    // Consumer drains the held word; a capture below may refill it.
    if (valid_q && out_bus.o_ready) valid_d = 1'b0;

    unique case (state_q)
      WAIT_DATA: begin
        if (complete_s && bad_s) begin
          // Illegal wave is acknowledged so upstream can return to NULL,
          // independent of output backpressure.
          err_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = WAIT_NULL;
        end else if (complete_s && slot_free) begin
          result_d = result_true;
          flag_d   = rails_s[2*WIDTH+1];
          valid_d  = 1'b1;
          ack_d    = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = WAIT_NULL;
        end
        // Complete but no free slot: withholding ack stalls upstream.
      end
      WAIT_NULL: begin
        if (null_s) begin
          ack_d   = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      default: state_d = WAIT_DATA;
    endcase
  end

  assign ack_o            = ack_q;
  assign out_bus.o_valid  = valid_q;
  assign out_bus.o_result = result_q;
  assign out_bus.o_flag   = flag_q;
  assign err_illegal      = err_q;
  assign word_cnt         = cnt_q;
  assign dbg_state_o      = state_q;

endmodule

// File: doc/dr_flag_capture.md
Name: dr_flag_capture

Overview:
- Clocked consumer stage directly downstream of the dual-rail ALU flag detector.
- Samples the detector's dual-rail flag together with the dual-rail ALU result, and detects DATA completeness and NULL spacers.
- Converts the captured word to single-rail, presents it on a valid/ready interface to synchronous logic, and closes the four-phase loop back to the dual-rail pipeline with an ack rail.
- Flags illegal rail codes and counts delivered words.

Parameters:
- WIDTH, 2, number of dual-rail result bits captured alongside the flag.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_result_dr  input  2*WIDTH  dual-rail result; pair i = {[2i+1] true rail, [2i] false rail}.
- in_flag_dr  input  2  dual-rail flag from detector; [1] true rail, [0] false rail.
- ack_o  output  1  four-phase acknowledge to upstream dual-rail pipeline.
- o_valid  output  1  single-rail word available.
- o_ready  input  1  consumer accepts word when o_valid && o_ready.
- o_result  output  WIDTH  single-rail result (true rails of captured word).
- o_flag  output  1  single-rail flag.
- err_illegal  output  1  sticky illegal-code indicator.
- word_cnt  output  CNT_W  count of words delivered to o_valid.

Behaviour:
- Rail codes per pair: 00 NULL, 10 DATA1, 01 DATA0, 11 illegal.
- Input conditioning:
  - All 2*WIDTH+2 rails pass through a 2-flop synchronizer (s1, s2).
  - s3 holds the previous s2.
  - "stable" = (s2 == s3).
  - "complete" = stable and every pair in s2 is non-00.
  - "null" = stable and every pair in s2 is 00.
  - "bad" = complete and any pair is 11.
- Reset values: s1/s2/s3 = 0 (NULL), state WAIT_DATA, ack_o=0, o_valid=0, o_result=0, o_flag=0, err_illegal=0, word_cnt=0.
- FSM, 2 states:
  - WAIT_DATA:
    - complete && !bad && slot_free, where slot_free = !o_valid || o_ready: capture. o_result <= true rails, o_flag <= flag true rail, o_valid <= 1, ack_o <= 1, word_cnt <= word_cnt+1 (wraps modulo 2^CNT_W), go WAIT_NULL.
    - complete && bad: err_illegal <= 1, ack_o <= 1, no capture, o_valid unaffected, word_cnt unchanged, go WAIT_NULL. The bad word is not gated by slot_free.
    - complete && !bad && !slot_free: hold. ack_o stays 0, which backpressures upstream.
    - Otherwise (partial/mixed or unstable): hold.
  - WAIT_NULL:
    - null: ack_o <= 0, go WAIT_DATA.
    - Otherwise hold with ack_o=1. A second DATA wave without an intervening NULL is impossible under protocol and is ignored.
- Output handshake:
  - o_valid clears on a cycle with o_ready=1 and no new capture.
  - Capture and accept on the same edge: o_valid stays 1 with the new word.
  - o_result/o_flag are stable while o_valid && !o_ready.
- Latency: rails settled before edge 1 give s1@1, s2@2, stable@3, so o_valid and ack_o rise on edge 4. NULL ack release follows the same 4 edges.
- err_illegal is cleared only by rst_n.
- Reset mid-operation:
  - All state clears asynchronously and ack_o drops immediately.
  - If DATA is held at reset release, it is captured 4 edges after release.

Decomposition:
- Shared package: rail-code constants (DR_NULL=2'b00, DR_ONE=2'b10, DR_ZERO=2'b01, DR_ILL=2'b11), FSM state typedef (WAIT_DATA, WAIT_NULL), and a function for pair completeness/illegality.
- One natural sub-module: dr_sync_stable (parameterised rail width; 2-flop synchronizer plus s3 compare, outputs stable/complete/null/bad).
- FSM, output register, and counter stay in the top module.

Test Plan:
- Reset then WIDTH=2 result 10,01 with flag 10 held from cycle 0, o_ready=1 -> edge 4: o_valid=1, o_result=2'b10, o_flag=1, ack_o=1, word_cnt=1. NULL applied -> ack_o=0 four edges later.
- o_ready=0 with first word pending, second DATA wave flag=01 after NULL -> ack_o stays 0. Raise o_ready -> next edge: o_result/o_flag = second word, word_cnt=2.
- Flag pair 11 with valid result -> err_illegal=1 and ack_o=1 at edge 4, o_valid stays 0, word_cnt unchanged. After NULL plus reset -> err_illegal=0.
- Staggered arrival: result rails complete at cycle 0, flag rails at cycle 5 -> no capture until edge 9, ack_o=0 throughout.
- Glitch: flag 10 for one cycle, then 00 -> never stable, no capture, ack_o stays 0.
- CNT_W=2, five full DATA/NULL cycles with o_ready=1 -> word_cnt sequence 1,2,3,0,1. Assert rst_n low mid-WAIT_NULL -> ack_o, o_valid, word_cnt = 0 without a clock edge.
